// File: rtl/vga_pkg.sv
// Shared types, screen geometry and clipping helpers for the VGA draw scheduler.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Bit positions of the fields in the packed CPU pixel word.
  localparam int Y_MSB = 30;
  localparam int Y_LSB = 24;
  localparam int X_MSB = 23;
  localparam int X_LSB = 16;
  localparam int C_MSB = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y,
                                     input logic [7:0] w_lim, input logic [6:0] h_lim);
    return (x < w_lim) && (y < h_lim);
  endfunction

  // End coordinates are exclusive and computed one bit wider, so large sizes never wrap.
  function automatic logic [7:0] clip_x_end(input logic [7:0] x0, input logic [7:0] w,
                                            input logic [7:0] lim);
    logic [8:0] sum;
    sum = {1'b0, x0} + {1'b0, w};
    return (sum > {1'b0, lim}) ? lim : sum[7:0];
  endfunction

  function automatic logic [6:0] clip_y_end(input logic [6:0] y0, input logic [6:0] h,
                                            input logic [6:0] lim);
    logic [7:0] sum;
    sum = {1'b0, y0} + {1'b0, h};
    return (sum > {1'b0, lim}) ? lim : sum[6:0];
  endfunction

endpackage

// File: rtl/vga_draw_scheduler_if.sv
// Bundle of the CPU pixel path, rectangle command path, status and VGA plot port.
interface vga_draw_scheduler_if;

  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] pix_data;
  logic        fill_valid;
  logic        fill_ready;
  logic [7:0]  fill_x;
  logic [6:0]  fill_y;
  logic [7:0]  fill_w;
  logic [6:0]  fill_h;
  logic [2:0]  fill_colour;
  logic        busy;
  logic        fill_done;
  logic        vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  modport master (
    output pix_valid, pix_data, fill_valid, fill_x, fill_y, fill_w, fill_h, fill_colour,
    input  pix_ready, fill_ready, busy, fill_done, vga_plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  pix_valid, pix_data, fill_valid, fill_x, fill_y, fill_w, fill_h, fill_colour,
    output pix_ready, fill_ready, busy, fill_done, vga_plot, vga_x, vga_y, vga_colour
  );

endinterface

// File: rtl/vga_draw_scheduler.sv
// Arbitrates the VGA plot port between single CPU pixels and a rectangle-fill walker,
// with a stall counter that guarantees the fill forward progress under pixel traffic.
module vga_draw_scheduler #(
  parameter int SCREEN_W  = vga_pkg::SCREEN_W,
  parameter int SCREEN_H  = vga_pkg::SCREEN_H,
  parameter int STALL_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_draw_scheduler_if.slave   bus
);

  import vga_pkg::*;

  localparam int STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [7:0] W_LIM = 8'(SCREEN_W);
  localparam logic [6:0] H_LIM = 7'(SCREEN_H);

  state_e             state_q;
  logic [STALL_W-1:0] stall_q;
  logic [7:0]         x0_q;
  logic [7:0]         cx_q;
  logic [6:0]         cy_q;
  logic [7:0]         x_end_q;
  logic [6:0]         y_end_q;
  logic [2:0]         colour_q;
  logic               vga_plot_q;
  logic [7:0]         vga_x_q;
  logic [6:0]         vga_y_q;
  logic [2:0]         vga_colour_q;
  logic               fill_done_q;

  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_c;
  logic       hold_off;
  logic       pix_xfer;
  logic       fill_xfer;
  logic [7:0] x_end_d;
  logic [6:0] y_end_d;
  logic       fill_empty;
  logic       last_x;
  logic       last_y;
  logic       unused_pix_bits;

  assign pix_x = bus.pix_data[X_MSB:X_LSB];
  assign pix_y = bus.pix_data[Y_MSB:Y_LSB];
  assign pix_c = bus.pix_data[C_MSB:0];
  assign unused_pix_bits = ^{bus.pix_data[31], bus.pix_data[15:3]};

  // A starved fill takes the port for one cycle once STALL_MAX pixels in a row have won.
  assign hold_off  = (state_q == FILL) && (stall_q == STALL_W'(STALL_MAX));
  assign pix_xfer  = bus.pix_valid && !hold_off;
  assign fill_xfer = bus.fill_valid && (state_q == IDLE);

  assign x_end_d    = clip_x_end(bus.fill_x, bus.fill_w, W_LIM);
  assign y_end_d    = clip_y_end(bus.fill_y, bus.fill_h, H_LIM);
  assign fill_empty = (bus.fill_w == 8'd0) || (bus.fill_h == 7'd0) ||
                      !on_screen(bus.fill_x, bus.fill_y, W_LIM, H_LIM);

  assign last_x = ({1'b0, cx_q} + 9'd1) == {1'b0, x_end_q};
  assign last_y = ({1'b0, cy_q} + 8'd1) == {1'b0, y_end_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      stall_q      <= '0;
      x0_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      colour_q     <= '0;
      vga_plot_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      fill_done_q  <= 1'b0;
    end else begin
      vga_plot_q  <= 1'b0;
      fill_done_q <= 1'b0;

      if (pix_xfer) begin
        vga_x_q      <= pix_x;
        vga_y_q      <= pix_y;
        vga_colour_q <= pix_c;
        vga_plot_q   <= on_screen(pix_x, pix_y, W_LIM, H_LIM);
      end

      case (state_q)
        IDLE: begin
          stall_q <= '0;
          if (fill_xfer) begin
            x0_q     <= bus.fill_x;
            cx_q     <= bus.fill_x;
            cy_q     <= bus.fill_y;
            colour_q <= bus.fill_colour;
            x_end_q  <= x_end_d;
            y_end_q  <= y_end_d;
            if (fill_empty) begin
              fill_done_q <= 1'b1;
            end else begin
              state_q <= FILL;
            end
          end
        end

        FILL: begin
          if (pix_xfer) begin
            stall_q <= stall_q + STALL_W'(1);
          end else begin
            stall_q      <= '0;
            vga_x_q      <= cx_q;
            vga_y_q      <= cy_q;
            vga_colour_q <= colour_q;
            vga_plot_q   <= 1'b1;
            if (last_x) begin
              cx_q <= x0_q;
              if (last_y) begin
                state_q     <= IDLE;
                fill_done_q <= 1'b1;
              end else begin
                cy_q <= cy_q + 7'd1;
              end
            end else begin
              cx_q <= cx_q + 8'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pix_ready  = !hold_off;
  assign bus.fill_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == FILL);
  assign bus.fill_done  = fill_done_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Scoreboard bench for vga_draw_scheduler: every plot / fill_done event is matched,
// including its cycle stamp, against events queued when the stimulus was driven.
module tb_vga_draw_scheduler;

  typedef struct {
    int         cyc;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       done;
  } event_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     cyc = 0;
  int     nChecks = 0;
  int     nFail = 0;
  event_t expQ[$];
  event_t monExp;
  event_t monAct;

  vga_draw_scheduler_if bus();

  vga_draw_scheduler #(
    .STALL_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic logic [63:0] packEv(input event_t e, input logic plotMask);
    if (plotMask)
      return {28'b0, 16'(e.cyc), e.done, e.plot, e.x, e.y, e.c};
    else
      return {28'b0, 16'(e.cyc), e.done, e.plot, 18'b0};
  endfunction

  function automatic logic [31:0] pixWord(input logic [7:0] x, input logic [6:0] y,
                                          input logic [2:0] c);
    return {1'b0, y, x, 13'b0, c};
  endfunction

  task automatic expectEv(input int c, input logic plot, input logic [7:0] x,
                          input logic [6:0] y, input logic [2:0] col, input logic done);
    event_t e;
    e.cyc = c; e.plot = plot; e.x = x; e.y = y; e.c = col; e.done = done;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic pv, input logic [31:0] pd, input logic fv,
                               input logic [7:0] fx, input logic [6:0] fy,
                               input logic [7:0] fw, input logic [6:0] fh,
                               input logic [2:0] fc);
    bus.pix_valid   = pv;
    bus.pix_data    = pd;
    bus.fill_valid  = fv;
    bus.fill_x      = fx;
    bus.fill_y      = fy;
    bus.fill_w      = fw;
    bus.fill_h      = fh;
    bus.fill_colour = fc;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 3'd0);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      idleCycles(1);
      n++;
    end
    checkOutput("drain", 64'(expQ.size()), 64'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " plot"},   64'(bus.vga_plot),   64'd0);
    checkOutput({tag, " x"},      64'(bus.vga_x),      64'd0);
    checkOutput({tag, " y"},      64'(bus.vga_y),      64'd0);
    checkOutput({tag, " colour"}, 64'(bus.vga_colour), 64'd0);
    checkOutput({tag, " done"},   64'(bus.fill_done),  64'd0);
    checkOutput({tag, " busy"},   64'(bus.busy),       64'd0);
    checkOutput({tag, " fready"}, 64'(bus.fill_ready), 64'd1);
    checkOutput({tag, " pready"}, 64'(bus.pix_ready),  64'd1);
  endtask

  // Monitor: every visible event must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.vga_plot === 1'b1 || bus.fill_done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious event", {62'b0, bus.vga_plot, bus.fill_done}, 64'd0);
      end else begin
        monExp = expQ.pop_front();
        monAct.cyc = cyc; monAct.plot = bus.vga_plot; monAct.x = bus.vga_x;
        monAct.y = bus.vga_y; monAct.c = bus.vga_colour; monAct.done = bus.fill_done;
        checkOutput("plot event", packEv(monAct, monExp.plot), packEv(monExp, monExp.plot));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   stall;
    int   fillIdx;
    logic holdoff;

    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.fill_valid = 1'b0;
    bus.fill_x = '0; bus.fill_y = '0; bus.fill_w = '0; bus.fill_h = '0; bus.fill_colour = '0;
    rst = 1'b1;
    idleCycles(2);
    checkResetState("reset");
    rst = 1'b0;
    idleCycles(1);

    $display("[TB] single on-screen pixel");
    expectEv(cyc + 1, 1'b1, 8'd10, 7'd5, 3'd3, 1'b0);
    applyStimulus(1'b1, 32'h050A_0003, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 3'd0);
    idleCycles(1);
    checkOutput("pixel plot drops", 64'(bus.vga_plot), 64'd0);
    waitDrain(4);

    $display("[TB] off-screen pixel");
    checkOutput("offscreen pready", 64'(bus.pix_ready), 64'd1);
    applyStimulus(1'b1, pixWord(8'd200, 7'd5, 3'd1), 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 3'd0);
    checkOutput("offscreen plot", 64'(bus.vga_plot), 64'd0);
    checkOutput("offscreen x", 64'(bus.vga_x), 64'd200);
    idleCycles(1);

    $display("[TB] 2x2 fill");
    checkOutput("fill_ready idle", 64'(bus.fill_ready), 64'd1);
    expectEv(cyc + 2, 1'b1, 8'd2, 7'd3, 3'd6, 1'b0);
    expectEv(cyc + 3, 1'b1, 8'd3, 7'd3, 3'd6, 1'b0);
    expectEv(cyc + 4, 1'b1, 8'd2, 7'd4, 3'd6, 1'b0);
    expectEv(cyc + 5, 1'b1, 8'd3, 7'd4, 3'd6, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'd2, 7'd3, 8'd2, 7'd2, 3'd6);
    checkOutput("busy in fill", 64'(bus.busy), 64'd1);
    checkOutput("fill_ready in fill", 64'(bus.fill_ready), 64'd0);
    waitDrain(10);
    checkOutput("fill_ready after", 64'(bus.fill_ready), 64'd1);
    checkOutput("busy after", 64'(bus.busy), 64'd0);

    $display("[TB] clipped fill");
    expectEv(cyc + 2, 1'b1, 8'd158, 7'd118, 3'd2, 1'b0);
    expectEv(cyc + 3, 1'b1, 8'd159, 7'd118, 3'd2, 1'b0);
    expectEv(cyc + 4, 1'b1, 8'd158, 7'd119, 3'd2, 1'b0);
    expectEv(cyc + 5, 1'b1, 8'd159, 7'd119, 3'd2, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'd158, 7'd118, 8'd10, 7'd10, 3'd2);
    waitDrain(10);
    idleCycles(2);

    $display("[TB] degenerate fills");
    expectEv(cyc + 1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'd10, 7'd10, 8'd0, 7'd4, 3'd1);
    checkOutput("zero-w busy", 64'(bus.busy), 64'd0);
    idleCycles(2);
    expectEv(cyc + 1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'd170, 7'd10, 8'd5, 7'd5, 3'd1);
    idleCycles(2);
    expectEv(cyc + 1, 1'b0, 8'd0, 7'd0, 3'd0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'd10, 7'd120, 8'd5, 7'd5, 3'd1);
    waitDrain(4);

    $display("[TB] contention 8x1 fill against continuous pixels");
    expectEv(cyc + 1, 1'b1, 8'd0, 7'd50, 3'd0, 1'b0);
    applyStimulus(1'b1, pixWord(8'd0, 7'd50, 3'd0), 1'b1, 8'd20, 7'd10, 8'd8, 7'd1, 3'd5);
    stall = 0;
    fillIdx = 0;
    for (int i = 1; i <= 42; i++) begin
      holdoff = (fillIdx < 8) && (stall == 4);
      checkOutput("contention pready", 64'(bus.pix_ready), 64'(!holdoff));
      if (holdoff) begin
        expectEv(cyc + 1, 1'b1, 8'(20 + fillIdx), 7'd10, 3'd5, fillIdx == 7);
        fillIdx++;
        stall = 0;
      end else begin
        expectEv(cyc + 1, 1'b1, 8'(i), 7'd50, 3'(i), 1'b0);
        if (fillIdx < 8) stall++;
      end
      applyStimulus(1'b1, pixWord(8'(i), 7'd50, 3'(i)), 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 3'd0);
    end
    waitDrain(6);
    checkOutput("contention busy", 64'(bus.busy), 64'd0);

    $display("[TB] reset mid-fill");
    expectEv(cyc + 2, 1'b1, 8'd0, 7'd0, 3'd7, 1'b0);
    expectEv(cyc + 3, 1'b1, 8'd1, 7'd0, 3'd7, 1'b0);
    expectEv(cyc + 4, 1'b1, 8'd2, 7'd0, 3'd7, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'd0, 7'd0, 8'd10, 7'd10, 3'd7);
    idleCycles(3);
    checkOutput("busy before reset", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    idleCycles(1);
    checkResetState("mid-fill reset");
    rst = 1'b0;
    waitDrain(0);
    idleCycles(2);
    checkOutput("post-reset quiet", 64'(bus.vga_plot), 64'd0);
    expectEv(cyc + 2, 1'b1, 8'd5, 7'd5, 3'd4, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'd5, 7'd5, 8'd1, 7'd1, 3'd4);
    waitDrain(6);
    idleCycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/vga_draw_scheduler.md
Name: vga_draw_scheduler

Overview:
Sequencer and arbiter in front of the VGA adapter plot port (vga_plot/vga_x/vga_y/vga_colour).
- Shares the port between two requesters:
  - the CPU single-pixel path, using the same 32-bit packed word as the existing VGA control path;
  - a rectangle-fill engine that walks a clipped rectangle at one pixel per cycle.
- Registered outputs drive the VGA adapter directly.
- Reports fill completion to the CPU-side peripheral logic.

Parameters:
SCREEN_W, 160, visible width in pixels; x legal range 0..SCREEN_W-1.
SCREEN_H, 120, visible height in pixels; y legal range 0..SCREEN_H-1.
STALL_MAX, 4, consecutive fill cycles lost to pixel traffic before the pixel path is held off for one cycle.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pix_valid  in  1  single-pixel request
pix_ready  out  1  single-pixel accept; transfer occurs when pix_valid && pix_ready
pix_data  in  32  [30:24] y, [23:16] x, [2:0] colour; other bits ignored
fill_valid  in  1  rectangle command request
fill_ready  out  1  high only in IDLE; transfer occurs when fill_valid && fill_ready
fill_x  in  8  left edge
fill_y  in  7  top edge
fill_w  in  8  width in pixels
fill_h  in  7  height in pixels
fill_colour  in  3  fill colour
busy  out  1  high while in FILL
fill_done  out  1  one-cycle pulse when a fill command retires
vga_plot  out  1  plot strobe to the VGA adapter
vga_x  out  8  pixel x
vga_y  out  7  pixel y
vga_colour  out  3  pixel colour

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst). Reset applies in any state, including mid-fill, and has priority over all other inputs.
- Reset values:
  - FSM = IDLE; stall counter = 0.
  - vga_plot = vga_x = vga_y = vga_colour = 0.
  - fill_done = busy = 0; fill_ready = 1.
  - An in-progress rectangle is discarded.
- All VGA outputs are registered. An accepted pixel appears on the port exactly 1 cycle after its transfer cycle.
- Pixel path:
  - pix_ready = 1 except during a hold-off cycle (see starvation rule).
  - Accepted pixel:
    - vga_x/vga_y/vga_colour take the pix_data fields next cycle.
    - vga_plot = 1 only if x < SCREEN_W and y < SCREEN_H.
    - An off-screen pixel is consumed with vga_plot = 0 and is never stalled.
- FSM states:
  - IDLE:
    - fill_ready = 1.
    - On a fill transfer, latch x0, y0, colour. Compute x_end = min(x0+w, SCREEN_W) with 9-bit add and y_end = min(y0+h, SCREEN_H) with 8-bit add; no wrap.
    - If w == 0, h == 0, x0 >= SCREEN_W or y0 >= SCREEN_H: stay in IDLE and pulse fill_done next cycle.
    - Otherwise set cx = x0, cy = y0 and go to FILL.
  - FILL:
    - Each cycle with no pixel transfer, emit (cx, cy, colour) with vga_plot = 1 on the next cycle.
    - Advance in raster order, x inner: cx++; when cx+1 == x_end, cx = x0 and cy++.
    - On emitting (x_end-1, y_end-1), return to IDLE and pulse fill_done together with that last plot.
- Arbitration: a simultaneous pixel transfer wins the port. The fill does not advance that cycle and the stall counter increments.
- Starvation rule:
  - When the stall counter reaches STALL_MAX, the next FILL cycle is a hold-off: pix_ready = 0, the fill advances, and the counter clears.
  - The counter also clears on any non-stalled fill cycle.
- A pixel transfer in IDLE coincident with a fill transfer is legal. The pixel plots next cycle; FILL starts the cycle after.
- When no transfer is active, vga_plot = 0 and x/y/colour hold their last values.

Decomposition:
- Shared package vga_pkg:
  - SCREEN_W/SCREEN_H localparams;
  - state enum {IDLE, FILL};
  - packed-pixel field positions (Y_MSB=30, Y_LSB=24, X_MSB=23, X_LSB=16, C_MSB=2).
- No sub-module required. Optionally factor clipping into vga_clip (pure combinational on-screen check plus min-end computation), reused by both paths.

Test Plan:
- Single pixel pix_data=0x05_0A_00_03 (y=5, x=10, c=3) -> next cycle vga_plot=1, x=10, y=5, colour=3; following cycle vga_plot=0.
- Off-screen pixel x=200, y=5 -> pix_ready=1, next cycle vga_plot=0, no stall.
- Fill x=2, y=3, w=2, h=2, c=6 -> busy; plots in order (2,3), (3,3), (2,4), (3,4) on 4 consecutive cycles; fill_done with 4th plot; fill_ready=1 next cycle.
- Clipped fill x=158, y=118, w=10, h=10 -> exactly 4 plots: (158,118), (159,118), (158,119), (159,119); zero-size fill w=0 -> no plot, fill_done 1 cycle after transfer.
- Contention: fill 8x1 with pix_valid held high -> pixels win 4 cycles, then one hold-off cycle with pix_ready=0 and one fill plot; pattern repeats until all 8 fill pixels are emitted.
- rst=1 for one cycle mid-fill -> next cycle all outputs 0, fill_ready=1, busy=0, no fill_done; a subsequent fill starts cleanly.
